ldst_ctrl: RTL
==============

LDST_CTRL -- requirements
Module: ldst_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum MEM-state cycles waiting for mem_ready before abort (range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a load or store; sampled only in IDLE.
REQ-005 SHALL have port is_store, input, 1: 1 = store (sd), 0 = load (ld); sampled with start.
REQ-006 SHALL have ports rs1 and rs2_rd, input, 5 each: base register, and store-data register (store) or destination register (load); sampled with start.
REQ-007 SHALL have port offset, input, 64: signed immediate; sampled with start.
REQ-008 SHALL have ports rf_raddr1 and rf_raddr2, output, 5 each; rf_rdata1 and rf_rdata2, input, 64 each: combinational register-file read ports.
REQ-009 SHALL have ports rf_we, output, 1; rf_waddr, output, 5; rf_wdata, output, 64: register-file write port.
REQ-010 SHALL have ports mem_req, mem_we, output, 1; mem_addr, mem_wdata, output, 64; mem_rdata, input, 64; mem_ready, input, 1: data-memory port.
REQ-011 SHALL have outputs busy, done, err, each 1: busy = state not IDLE; done = completion pulse; err = error flag, valid while done=1.

Function
REQ-012 SHALL implement states IDLE, REG, ADDR, MEM, WB, DONE, with a registered encoding.
REQ-013 IDLE, start=1: SHALL latch is_store, rs1, rs2_rd and offset, then enter REG; start=0 stays in IDLE; start outside IDLE SHALL be ignored.
REQ-014 REG: SHALL drive rf_raddr1=latched rs1 and rf_raddr2=latched rs2_rd, capture rf_rdata1 into base and rf_rdata2 into sdata, then enter ADDR.
REQ-015 ADDR: SHALL register addr = base + offset, modulo 2^64 (wrap, no overflow flag).
REQ-016 ADDR exit: if addr[2:0] != 0 (misaligned doubleword), the next state SHALL be DONE with err=1 and no memory or register-file access; otherwise MEM.
REQ-017 MEM: SHALL hold mem_req=1, mem_addr=addr and mem_we=is_store; for a store, mem_wdata SHALL equal sdata.
REQ-018 MEM, load: on an edge with mem_ready=1, SHALL capture mem_rdata and enter WB.
REQ-019 MEM, store: on an edge with mem_ready=1, SHALL enter DONE.
REQ-020 MEM timeout: a wait counter SHALL clear on entry to MEM and increment each MEM cycle without mem_ready. When it reaches TIMEOUT with mem_ready still 0, the next state SHALL be DONE with err=1 and no write-back.
REQ-021 Timeout vs. ready: mem_ready=1 in the same cycle as the timeout condition SHALL win (normal completion).
REQ-022 WB: SHALL assert rf_we for exactly one cycle, with rf_waddr=rs2_rd and rf_wdata=captured data. If rs2_rd=0, rf_we SHALL stay 0 (x0 is read-only), but the operation still completes.
REQ-023 DONE: SHALL assert done for exactly one cycle, with err valid, then return to IDLE. A start in the DONE cycle SHALL be ignored.
REQ-024 Aligned load with mem_ready held at 1: the edges after the start edge SHALL be REG, ADDR, MEM, WB, DONE, so done is high in the 5th cycle after the start edge; a store SHALL take 4 cycles.
REQ-025 SHALL drive mem_req, mem_we and rf_we to 0 in every state not named above; mem_addr, mem_wdata and rf_wdata SHALL be don't-care when their strobe is low.
REQ-026 err SHALL hold its value until the next accepted start, which clears it.

Reset
REQ-027 Reset SHALL asynchronously force state=IDLE and clear busy, done, err, mem_req, mem_we, rf_we, the wait counter, and all latched operands and data (0).
REQ-028 Reset asserted mid-operation (any state) SHALL abort with no further mem_req or rf_we, and SHALL produce no done pulse.
REQ-029 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-030 Load: rs1=2 (rf[2]=0x100), offset=0x8, rs2_rd=6, mem_ready=1, mem_rdata=0xDEADBEEF -> mem_addr=0x108, mem_we=0, rf_we=1 with waddr=6 and wdata=0xDEADBEEF, done in the 5th cycle, err=0.
REQ-031 Store: rs1=6 (rf[6]=0x200), rs2_rd=7 (rf[7]=0x55AA), offset=-8 -> mem_addr=0x1F8, mem_we=1, mem_wdata=0x55AA, rf_we never 1, done in the 4th cycle.
REQ-032 Misaligned: rf[2]=0x100, offset=0x6 -> mem_req never 1, done with err=1.
REQ-033 Timeout: mem_ready held at 0 with TIMEOUT=15 -> mem_req high for 15 cycles, then done with err=1, rf_we never 1. Rerun with mem_ready=1 in the 15th MEM cycle -> normal completion, err=0.
REQ-034 Load to x0 (rs2_rd=0) -> rf_we stays 0, done=1, err=0. Address wrap: base=0xFFFFFFFFFFFFFFF8, offset=0x10 -> mem_addr=0x8.
REQ-035 Reset in MEM state -> mem_req drops immediately, busy=0, no done pulse. A start 1 cycle after release is accepted and completes normally; a start pulsed while busy is ignored.

Source files
------------

// File: rtl/ldst_ctrl.sv
// Purpose: sequences one 64-bit doubleword load/store: RF read, address add, memory access, RF write-back.
// Latency: start edge -> done pulse in the 5th cycle (load) or the 4th cycle (store) when mem_ready is held high.
// Backpressure: waits in MEM for mem_ready up to TIMEOUT cycles, then aborts with err; start is ignored while busy.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   start/is_store/rs1/rs2_rd/offset   request, sampled only in IDLE
//   rf_raddr1/2, rf_rdata1/2     combinational register-file read ports
//   rf_we/rf_waddr/rf_wdata      register-file write port (load write-back)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready   data-memory port
//   busy/done/err                status; err is valid while done=1 and holds until the next start
module ldst_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2_rd,
  input  logic [63:0] offset,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [63:0] rf_rdata1,
  input  logic [63:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REG  = 3'd1,
    S_ADDR = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Last wait-count value before giving up on mem_ready.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_is_store;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rd;
  logic [63:0] r_offset;
  logic [63:0] r_base;
  logic [63:0] r_sdata;
  logic [63:0] r_addr;
  logic [63:0] r_rdata;
  logic [7:0]  r_wait;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        r_rf_we;

  // Wrapping 64-bit add; the alignment decision uses this sum in the same cycle it is registered.
  logic [63:0] w_addr;
  assign w_addr = r_base + r_offset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_rs1      <= '0;
      r_rd       <= '0;
      r_offset   <= '0;
      r_base     <= '0;
      r_sdata    <= '0;
      r_addr     <= '0;
      r_rdata    <= '0;
      r_wait     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_rf_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store <= is_store;
            r_rs1      <= rs1;
            r_rd       <= rs2_rd;
            r_offset   <= offset;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_REG;
          end
        end
        S_REG: begin
          r_base  <= rf_rdata1;
          r_sdata <= rf_rdata2;
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          r_addr <= w_addr;
          r_wait <= '0;
          if (w_addr[2:0] != 3'b000) begin
            // Misaligned doubleword: skip memory and write-back entirely.
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we  <= r_is_store;
            r_state   <= S_MEM;
          end
        end
        S_MEM: begin
          // mem_ready takes priority over the timeout in the same cycle.
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_is_store) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rdata <= mem_rdata;
              r_rf_we <= (r_rd != 5'd0);
              r_state <= S_WB;
            end
          end else if (r_wait == LP_WAIT_LAST) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_err     <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_rf_we <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_rf_we   <= 1'b0;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign rf_raddr1 = r_rs1;
  assign rf_raddr2 = r_rd;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rd;
  assign rf_wdata  = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_sdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
